// File: rtl/dm_cache_pkg.sv
//==============================================================================
// Module : dm_cache_pkg
// Brief  : Widths, FSM state type and address-field helpers for the
//          direct-mapped cache controller.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package dm_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 18;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 4;
    localparam int DATA_W   = 32;
    localparam int LINE_W   = 128;
    localparam int WORD_W   = OFFSET_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_COMPARE     = 3'd1,
        ST_WRITEBACK   = 3'd2,
        ST_ALLOCATE    = 3'd3,
        ST_WAIT_REFILL = 3'd4
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:2];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_cache_stats.sv
//==============================================================================
// Module : dm_cache_stats
// Brief  : Saturating hit / miss / write-back event counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dm_cache_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_lookup,
    input  logic             i_hit,
    input  logic             i_refill_done,
    input  logic             i_wb_done,
    output logic [CNT_W-1:0] o_hits,
    output logic [CNT_W-1:0] o_misses,
    output logic [CNT_W-1:0] o_wbs
);

    logic             relookup_q, relookup_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] misses_q, misses_d;
    logic [CNT_W-1:0] wbs_q, wbs_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    // The lookup that follows a refill always hits and must not be counted.
    always_comb begin
        relookup_d = relookup_q;
        if (i_accept)      relookup_d = 1'b0;
        if (i_refill_done) relookup_d = 1'b1;
        hits_d   = sat_inc(hits_q,   i_lookup &&  i_hit && !relookup_q);
        misses_d = sat_inc(misses_q, i_lookup && !i_hit && !relookup_q);
        wbs_d    = sat_inc(wbs_q,    i_wb_done);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            relookup_q <= 1'b0;
            hits_q     <= '0;
            misses_q   <= '0;
            wbs_q      <= '0;
        end else begin
            relookup_q <= relookup_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            wbs_q      <= wbs_d;
        end
    end

    assign o_hits   = hits_q;
    assign o_misses = misses_q;
    assign o_wbs    = wbs_q;

endmodule

`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
//==============================================================================
// Module : dm_cache_ctrl
// Brief  : Direct-mapped cache controller FSM (write-back, write-allocate).
//          Define CACHE_CTRL_STATS_EN to build the event counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dm_cache_ctrl
    import dm_cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req_valid,
    input  logic                cpu_req_rw,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    output logic                cpu_req_ready,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_rdata,
    output logic [INDEX_W-1:0]  ts_index,
    output logic [TAG_W-1:0]    ts_tag,
    output logic                ts_valid,
    output logic                ts_dirty,
    output logic                ts_we,
    input  logic                ts_hit,
    input  logic                ts_modify,
    input  logic [TAG_W-1:0]    ts_rd_tag,
    output logic [INDEX_W-1:0]  da_index,
    output logic                da_we,
    output logic [LINE_W-1:0]   da_wline,
    input  logic [LINE_W-1:0]   da_rline,
    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [LINE_W-1:0]   mem_req_wline,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [LINE_W-1:0]   mem_resp_rline,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_wbs
);

    state_t               state_q, state_d;
    logic                 rw_q, rw_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;

    logic [DATA_W-1:0]    w_load_word;
    logic [LINE_W-1:0]    w_store_line;

    always_comb begin
        w_load_word  = da_rline[word_q*DATA_W +: DATA_W];
        w_store_line = da_rline;
        w_store_line[word_q*DATA_W +: DATA_W] = wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rw_q         <= 1'b0;
            tag_q        <= '0;
            index_q      <= '0;
            word_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (cpu_req_valid) state_d = ST_COMPARE;
            ST_COMPARE: begin
                if (ts_hit)         state_d = ST_IDLE;
                else if (ts_modify) state_d = ST_WRITEBACK;
                else                state_d = ST_ALLOCATE;
            end
            ST_WRITEBACK:   if (mem_req_ready)  state_d = ST_ALLOCATE;
            ST_ALLOCATE:    if (mem_req_ready)  state_d = ST_WAIT_REFILL;
            ST_WAIT_REFILL: if (mem_resp_valid) state_d = ST_COMPARE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rw_d         = rw_q;
        tag_d        = tag_q;
        index_d      = index_q;
        word_d       = word_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        if (state_q == ST_IDLE && cpu_req_valid) begin
            rw_d    = cpu_req_rw;
            tag_d   = addr_tag(cpu_req_addr);
            index_d = addr_index(cpu_req_addr);
            word_d  = addr_word(cpu_req_addr);
            wdata_d = cpu_req_wdata;
        end
        if (state_q == ST_COMPARE && ts_hit) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = rw_q ? '0 : w_load_word;
        end
    end

    always_comb begin
        cpu_req_ready  = (state_q == ST_IDLE);
        cpu_resp_valid = resp_valid_q;
        cpu_resp_rdata = resp_rdata_q;
        ts_index       = index_q;
        ts_tag         = tag_q;
        da_index       = index_q;
        ts_valid       = 1'b0;
        ts_dirty       = 1'b0;
        ts_we          = 1'b0;
        da_we          = 1'b0;
        da_wline       = '0;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wline  = '0;
        case (state_q)
            ST_COMPARE: begin
                if (ts_hit && rw_q) begin
                    da_we    = 1'b1;
                    da_wline = w_store_line;
                    ts_we    = 1'b1;
                    ts_valid = 1'b1;
                    ts_dirty = 1'b1;
                end
            end
            // Victim address and data come straight from the arrays, which
            // are not written while the request is stalled.
            ST_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = line_addr(ts_rd_tag, index_q);
                mem_req_wline = da_rline;
            end
            ST_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_addr(tag_q, index_q);
            end
            ST_WAIT_REFILL: begin
                if (mem_resp_valid) begin
                    da_we    = 1'b1;
                    da_wline = mem_resp_rline;
                    ts_we    = 1'b1;
                    ts_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    dm_cache_stats #(.CNT_W(32)) u_stats (
        .clk           (clk),
        .reset         (reset),
        .i_accept      (state_q == ST_IDLE && cpu_req_valid),
        .i_lookup      (state_q == ST_COMPARE),
        .i_hit         (ts_hit),
        .i_refill_done (state_q == ST_WAIT_REFILL && mem_resp_valid),
        .i_wb_done     (state_q == ST_WRITEBACK && mem_req_ready),
        .o_hits        (stat_hits),
        .o_misses      (stat_misses),
        .o_wbs         (stat_wbs)
    );
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
    assign stat_wbs    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
//==============================================================================
// Module : tb_dm_cache_ctrl
// Brief  : Self-checking bench for dm_cache_ctrl with tag/data array and
//          memory models and a flat word-memory reference.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dm_cache_ctrl;
    import dm_cache_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                cpu_req_valid, cpu_req_rw;
    logic [ADDR_W-1:0]   cpu_req_addr;
    logic [DATA_W-1:0]   cpu_req_wdata;
    logic                cpu_req_ready, cpu_resp_valid;
    logic [DATA_W-1:0]   cpu_resp_rdata;
    logic [INDEX_W-1:0]  ts_index, da_index;
    logic [TAG_W-1:0]    ts_tag, ts_rd_tag;
    logic                ts_valid, ts_dirty, ts_we, ts_hit, ts_modify;
    logic                da_we;
    logic [LINE_W-1:0]   da_wline, da_rline;
    logic                mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [LINE_W-1:0]   mem_req_wline, mem_resp_rline;
    logic [31:0]         stat_hits, stat_misses, stat_wbs;

    always #5 clk = ~clk;

    dm_cache_ctrl u_dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata),
        .ts_index(ts_index), .ts_tag(ts_tag), .ts_valid(ts_valid), .ts_dirty(ts_dirty),
        .ts_we(ts_we), .ts_hit(ts_hit), .ts_modify(ts_modify), .ts_rd_tag(ts_rd_tag),
        .da_index(da_index), .da_we(da_we), .da_wline(da_wline), .da_rline(da_rline),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wline(mem_req_wline), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rline(mem_resp_rline),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // Tag store and data array models.
    logic [TAG_W-1:0]  ts_tags  [1024];
    logic              ts_vals  [1024] = '{default: 1'b0};
    logic              ts_dirts [1024] = '{default: 1'b0};
    logic [LINE_W-1:0] da_lines [1024] = '{default: '0};
    int                we_cnt = 0;

    always @(posedge clk) begin
        if (ts_we) begin
            ts_tags[ts_index]  <= ts_tag;
            ts_vals[ts_index]  <= ts_valid;
            ts_dirts[ts_index] <= ts_dirty;
        end
        if (da_we) da_lines[da_index] <= da_wline;
        if (ts_we || da_we) we_cnt <= we_cnt + 1;
    end

    assign ts_hit    = ts_vals[ts_index] && (ts_tags[ts_index] == ts_tag);
    assign ts_modify = ts_vals[ts_index] && ts_dirts[ts_index];
    assign ts_rd_tag = ts_tags[ts_index];
    assign da_rline  = da_lines[da_index];

    // Backing memory and the flat word-level reference.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [127:0] init_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = init_word(la + 32'(4*i));
        return l;
    endfunction

    logic [127:0] mem_lines [logic [31:0]];
    logic [31:0]  ref_words [logic [31:0]];

    function automatic logic [127:0] mem_get(input logic [31:0] la);
        return mem_lines.exists(la) ? mem_lines[la] : init_line(la);
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_words.exists(a) ? ref_words[a] : init_word(a);
    endfunction

    logic              ref_valid [1024] = '{default: 1'b0};
    logic              ref_dirty [1024] = '{default: 1'b0};
    logic [TAG_W-1:0]  ref_tag   [1024];
    int                m_hits = 0, m_misses = 0, m_wbs = 0;

    // Memory responder state.
    int           n_wb = 0, n_rd = 0;
    logic [31:0]  last_wb_addr = '0, last_rd_addr = '0;
    logic [127:0] last_wb_line = '0;
    int           pend_cnt = 0;
    logic [31:0]  pend_addr = '0;
    bit           hold_resp = 0, stall_arm = 0;
    int           stall_left = 0, stall_hold = 0;
    logic [31:0]  stall_addr = '0;
    int           viol = 0;
    bit           prev_v = 0, prev_hs = 0, prev_rw = 0;
    logic [31:0]  prev_addr = '0;
    logic [127:0] prev_wline = '0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rline = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (pend_cnt > 0 && !hold_resp) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rline = mem_get(pend_addr);
                end
            end
            if (reset && prev_v && !prev_hs &&
                (!mem_req_valid || mem_req_rw !== prev_rw ||
                 mem_req_addr !== prev_addr || mem_req_wline !== prev_wline))
                viol++;
            if (mem_req_valid && pend_cnt > 0) viol++;
            if (stall_arm && mem_req_valid) begin
                stall_arm  = 0;
                stall_left = 10;
                stall_addr = mem_req_addr;
            end
            if (stall_left > 0) begin
                stall_left--;
                mem_req_ready = 1'b0;
                if (mem_req_valid && !cpu_req_ready && mem_req_addr == stall_addr) stall_hold++;
            end else begin
                mem_req_ready = mem_req_valid && ($urandom_range(0, 3) != 0);
            end
            prev_hs    = mem_req_valid && mem_req_ready;
            prev_v     = mem_req_valid;
            prev_rw    = mem_req_rw;
            prev_addr  = mem_req_addr;
            prev_wline = mem_req_wline;
            if (prev_hs) begin
                if (mem_req_rw) begin
                    n_wb++;
                    last_wb_addr = mem_req_addr;
                    last_wb_line = mem_req_wline;
                    mem_lines[mem_req_addr] = mem_req_wline;
                end else begin
                    n_rd++;
                    last_rd_addr = mem_req_addr;
                    pend_cnt     = $urandom_range(1, 4);
                    pend_addr    = mem_req_addr;
                end
            end
        end
    end

    task automatic cpu_op(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tg;
        logic               p_hit, p_wb;
        logic [31:0]        p_wb_addr, exp_rdata;
        int                 wb0, rd0, lat;
        bit                 got;
        idx       = addr[13:4];
        tg        = addr[31:14];
        p_hit     = ref_valid[idx] && ref_tag[idx] == tg;
        p_wb      = !p_hit && ref_valid[idx] && ref_dirty[idx];
        p_wb_addr = {ref_tag[idx], idx, 4'b0};
        exp_rdata = rw ? 32'h0 : ref_get(addr);
        if (p_hit) m_hits++; else m_misses++;
        if (p_wb) m_wbs++;
        if (!p_hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_dirty[idx] = 1'b0;
        end
        if (rw) begin
            ref_words[addr] = wdata;
            ref_dirty[idx]  = 1'b1;
        end
        wb0 = n_wb;
        rd0 = n_rd;
        @(negedge clk);
        check_eq("ready_idle", 128'(cpu_req_ready), 128'(1));
        cpu_req_valid = 1'b1;
        cpu_req_rw    = rw;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        got = 0;
        lat = 0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check_eq("ready_busy", 128'(cpu_req_ready), 128'(0));
            if (cpu_resp_valid) begin
                got = 1;
                check_eq(rw ? "store_rdata" : "load_data", 128'(cpu_resp_rdata), 128'(exp_rdata));
            end
        end
        check_eq("resp_seen", 128'(got), 128'(1));
        if (p_hit) check_eq("hit_latency", 128'(lat), 128'(2));
        else       check_eq("miss_latency_gt2", 128'(lat > 2), 128'(1));
        check_eq("wb_count", 128'(n_wb - wb0), 128'(p_wb));
        check_eq("rd_count", 128'(n_rd - rd0), 128'(!p_hit));
        if (p_wb)   check_eq("wb_addr", 128'(last_wb_addr), 128'(p_wb_addr));
        if (!p_hit) check_eq("rd_addr", 128'(last_rd_addr), 128'({addr[31:4], 4'b0}));
        @(negedge clk);
        check_eq("resp_pulse", 128'(cpu_resp_valid), 128'(0));
    endtask

    localparam logic [31:0] RST_ADDR = {18'h5, 10'h3F0, 4'h0};

    initial begin
        logic [31:0] ra;
        int          rd0, lat, wc0;
        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready",     128'(cpu_req_ready),  128'(1));
        check_eq("rst_resp",      128'(cpu_resp_valid), 128'(0));
        check_eq("rst_mem_valid", 128'(mem_req_valid),  128'(0));
        check_eq("rst_we",        128'({ts_we, da_we}), 128'(0));
        check_eq("rst_index",     128'(ts_index),       128'(0));
        check_eq("rst_stats",     128'({stat_hits, stat_misses, stat_wbs}), 128'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        cpu_op(1'b0, 32'h0000_1010, 32'h0);
        cpu_op(1'b0, 32'h0000_1010, 32'h0);
        cpu_op(1'b1, 32'h0000_1014, 32'hDEAD_BEEF);
        cpu_op(1'b0, 32'h0000_1014, 32'h0);
        cpu_op(1'b0, 32'h0004_1010, 32'h0);
        check_eq("wb_line_word1", 128'(last_wb_line[63:32]), 128'(32'hDEAD_BEEF));
        stall_arm = 1;
        cpu_op(1'b0, 32'h0008_1010, 32'h0);
        check_eq("stall_hold", 128'(stall_hold), 128'(10));
        cpu_op(1'b0, 32'h0000_1014, 32'h0);

        for (int i = 0; i < 80; i++) begin
            ra = {18'($urandom_range(0, 3)), 10'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 2'b00};
            cpu_op(1'($urandom_range(0, 1)), ra, $urandom);
        end

        // Abort a refill with reset; the late refill must be ignored.
        hold_resp = 1;
        rd0 = n_rd;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = RST_ADDR;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0;
        while (n_rd == rd0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rst_reach_refill", 128'(n_rd - rd0), 128'(1));
        @(negedge clk);
        wc0 = we_cnt;
        reset = 1'b0;
        #1;
        check_eq("abort_ready",     128'(cpu_req_ready),  128'(1));
        check_eq("abort_mem_valid", 128'(mem_req_valid),  128'(0));
        check_eq("abort_we",        128'({ts_we, da_we}), 128'(0));
        @(negedge clk);
        reset     = 1'b1;
        hold_resp = 0;
        repeat (8) @(negedge clk);
        check_eq("abort_no_write",  128'(we_cnt - wc0),  128'(0));
        check_eq("abort_idle",      128'(cpu_req_ready), 128'(1));
        check_eq("abort_mem_quiet", 128'(mem_req_valid), 128'(0));
        m_hits   = 0;
        m_misses = 0;
        m_wbs    = 0;

        cpu_op(1'b0, RST_ADDR, 32'h0);
        cpu_op(1'b1, RST_ADDR + 32'h8, 32'h0BAD_F00D);
        cpu_op(1'b0, RST_ADDR + 32'h8, 32'h0);
        cpu_op(1'b0, {18'h9, 10'h3F0, 4'h8}, 32'h0);
        cpu_op(1'b0, RST_ADDR + 32'h8, 32'h0);

        check_eq("protocol_violations", 128'(viol), 128'(0));
`ifdef CACHE_CTRL_STATS_EN
        check_eq("stat_hits",   128'(stat_hits),   128'(m_hits));
        check_eq("stat_misses", 128'(stat_misses), 128'(m_misses));
        check_eq("stat_wbs",    128'(stat_wbs),    128'(m_wbs));
`else
        check_eq("stat_hits",   128'(stat_hits),   128'(0));
        check_eq("stat_misses", 128'(stat_misses), 128'(0));
        check_eq("stat_wbs",    128'(stat_wbs),    128'(0));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
